resp_encoder: RTL

- Converts the one-cycle response events from the command decoder ('K' write-ack, 'D' read-data, 'E' error) into an ordered byte stream for the UART transmitter.
- Sits between the decoder's response outputs and the uart_tx byte interface (valid/ready).
- Latches each response's fields on the event pulse, so the decoder may move on immediately.
- Holds one pending response while a frame is in flight.

---
 rtl/resp_pkg.sv | 33 +++
 rtl/resp_slot.sv | 35 +++
 rtl/resp_encoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/resp_pkg.sv
// Shared response-encoding constants and types for the response path.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: ASCII frame headers, error codes shared with the command decoder,
//           response-kind enum, encoder FSM states, captured-response struct.
package resp_pkg;

  localparam logic [7:0] RESP_K = 8'h4B;  // 'K' write acknowledge
  localparam logic [7:0] RESP_D = 8'h44;  // 'D' read data
  localparam logic [7:0] RESP_E = 8'h45;  // 'E' error

  localparam logic [7:0] ERR_UNKNOWN_CMD = 8'h01;
  localparam logic [7:0] ERR_BAD_ADDR    = 8'h02;

  typedef enum logic [1:0] {
    KIND_K = 2'd0,
    KIND_D = 2'd1,
    KIND_E = 2'd2
  } resp_kind_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } enc_state_e;

  typedef struct packed {
    resp_kind_e  kind;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  code;
  } resp_t;

endpackage

// File: rtl/resp_slot.sv
// Single-entry holding register for one captured response (fields + full flag).
// Latency: load/pop take effect on the next clk edge; load wins over pop.
// Backpressure: none; the owner decides when to load or pop.
// Ports: clk_i, rst_ni (sync, active-low), load_i, pop_i, resp_i -> resp_o, full_o.
module resp_slot
  import resp_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  load_i,
  input  logic  pop_i,
  input  resp_t resp_i,
  output resp_t resp_o,
  output logic  full_o
);

  resp_t resp_q;
  logic  full_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_q <= '0;
      full_q <= 1'b0;
    end else if (load_i) begin
      resp_q <= resp_i;
      full_q <= 1'b1;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign resp_o = resp_q;
  assign full_o = full_q;

endmodule

// File: rtl/resp_encoder.sv
// Serialises decoder response pulses (K/D/E) into a byte stream for uart_tx.
// Latency: pulse sampled at edge N -> header byte valid after edge N; frames run back-to-back.
// Backpressure: tx_valid/tx_data hold until tx_ready; one pending response is buffered, further ones drop.
// Ports: clk, rst_n (sync, active-low); resp_ok/resp_data/resp_err pulses with
//        resp_addr/resp_data_byte/resp_err_code; tx_data/tx_valid/tx_ready byte
//        handshake; busy, frame_done (same cycle as last-byte handshake), drop (cycle after).
module resp_encoder
  import resp_pkg::*;
#(
  parameter bit         EOL_EN   = 1'b1,
  parameter logic [7:0] EOL_BYTE = 8'h0A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       resp_ok,
  input  logic       resp_data,
  input  logic       resp_err,
  input  logic [7:0] resp_addr,
  input  logic [7:0] resp_data_byte,
  input  logic [7:0] resp_err_code,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       drop
);

  enc_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       drop_q, drop_d;
  logic       busy_q, busy_d;

  logic  ev;
  resp_t ev_resp;
  resp_t act_q, act_in, pnd_q;
  logic  act_full, pnd_full;
  logic  act_load, act_pop, act_sel_pnd;
  logic  pnd_load, pnd_pop;
  logic  hs, last_hs;
  logic [1:0] last_idx;

  assign ev = resp_ok | resp_data | resp_err;

  // Simultaneous pulses collapse to one response, E over D over K.
  always_comb begin
    ev_resp.addr = resp_addr;
    ev_resp.data = resp_data_byte;
    ev_resp.code = resp_err_code;
    if (resp_err)       ev_resp.kind = KIND_E;
    else if (resp_data) ev_resp.kind = KIND_D;
    else                ev_resp.kind = KIND_K;
  end

  assign act_in = act_sel_pnd ? pnd_q : ev_resp;

  resp_slot u_act (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (act_load),
    .pop_i  (act_pop),
    .resp_i (act_in),
    .resp_o (act_q),
    .full_o (act_full)
  );

  resp_slot u_pnd (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (pnd_load),
    .pop_i  (pnd_pop),
    .resp_i (ev_resp),
    .resp_o (pnd_q),
    .full_o (pnd_full)
  );

  assign tx_valid = (state_q == S_SEND) && act_full;
  assign hs       = tx_valid && tx_ready;

  always_comb begin
    last_idx = EOL_EN ? 2'd2 : 2'd1;
    if (act_q.kind == KIND_D) last_idx = EOL_EN ? 2'd3 : 2'd2;
  end

  assign last_hs    = hs && (idx_q == last_idx);
  assign frame_done = last_hs;

  // Byte mux: contents come only from the active capture register.
  always_comb begin
    tx_data = 8'h00;
    if (tx_valid) begin
      case (idx_q)
        2'd0: begin
          case (act_q.kind)
            KIND_D:  tx_data = RESP_D;
            KIND_E:  tx_data = RESP_E;
            default: tx_data = RESP_K;
          endcase
        end
        2'd1:    tx_data = (act_q.kind == KIND_E) ? act_q.code : act_q.addr;
        2'd2:    tx_data = (act_q.kind == KIND_D) ? act_q.data : EOL_BYTE;
        default: tx_data = EOL_BYTE;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    act_load    = 1'b0;
    act_pop     = 1'b0;
    act_sel_pnd = 1'b0;
    pnd_load    = 1'b0;
    pnd_pop     = 1'b0;
    drop_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ev) begin
          act_load = 1'b1;
          state_d  = S_SEND;
          idx_d    = 2'd0;
        end
      end
      default: begin
        if (hs) idx_d = idx_q + 2'd1;
        if (last_hs) begin
          idx_d = 2'd0;
          if (pnd_full) begin
            // Pending moves up; the slot is judged full at this edge, so a new event drops.
            act_load    = 1'b1;
            act_sel_pnd = 1'b1;
            pnd_pop     = 1'b1;
            drop_d      = ev;
          end else if (ev) begin
            // Empty slot at the closing edge: the event becomes the next frame directly.
            act_load = 1'b1;
          end else begin
            act_pop = 1'b1;
            state_d = S_IDLE;
          end
        end else if (ev) begin
          if (pnd_full) drop_d   = 1'b1;
          else          pnd_load = 1'b1;
        end
      end
    endcase
  end

  assign busy_d = (state_d != S_IDLE) || pnd_load || (pnd_full && !pnd_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign drop = drop_q;

endmodule
